// File: rtl/cnn_pool_pkg.sv
// Shared types and constants for the binary max-pooling window issuer.
// Holds the FSM state encoding, default widths and the window bit layout.
package cnn_pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL_B,
    ISSUE,
    WAIT,
    OUT
  } pool_state_e;

  localparam int DEF_ROW_W  = 72;
  localparam int DEF_RES_W  = 16;
  localparam int WIN_HI_MSB = 2 * DEF_ROW_W - 1;
  localparam int WIN_LO_MSB = DEF_ROW_W - 1;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/pool_window_issuer_if.sv
// Row stream, pooling-unit and result-stream signals of the window issuer.
// The issuer uses the master view; the pooling unit and stream peers use the slave view.
import cnn_pool_pkg::*;

interface pool_window_issuer_if #(
  parameter int ROW_W = DEF_ROW_W,
  parameter int RES_W = DEF_RES_W
);
  logic [ROW_W-1:0]   row_data;
  logic               row_valid;
  logic               row_ready;
  logic               pool_start;
  logic [2*ROW_W-1:0] pool_in;
  logic [RES_W-1:0]   pool_out;
  logic               pool_end;
  logic [RES_W-1:0]   res_data;
  logic               res_valid;
  logic               res_ready;
  logic               res_last;

  modport master (
    input  row_data, row_valid, pool_out, pool_end, res_ready,
    output row_ready, pool_start, pool_in, res_data, res_valid, res_last
  );

  modport slave (
    output row_data, row_valid, pool_out, pool_end, res_ready,
    input  row_ready, pool_start, pool_in, res_data, res_valid, res_last
  );
endinterface

// File: rtl/pool_window_issuer_timeout_cnt.sv
// Clearable wait counter for the pooling unit; expire marks the last cycle
// in which pool_end may still arrive before the window is abandoned.
import cnn_pool_pkg::*;

module pool_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Expiring at TIMEOUT-2 makes timeout_err visible TIMEOUT cycles after pool_start.
  assign expire = enable && (count == CNT_W'(TIMEOUT - 2));

endmodule

// File: rtl/pool_window_issuer.sv
// Pairs consecutive rows into a window, issues it to the pooling unit and
// forwards the pooled result with a frame-last marker.
import cnn_pool_pkg::*;

module pool_window_issuer #(
  parameter int ROW_W         = DEF_ROW_W,
  parameter int RES_W         = DEF_RES_W,
  parameter int WIN_PER_FRAME = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  pool_window_issuer_if.master         bus,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam logic [CNT_W-1:0] LAST_WIN = CNT_W'(WIN_PER_FRAME - 1);

  pool_state_e      state;
  logic [CNT_W-1:0] win_cnt;
  logic             expire;
  logic             row_hs;

  assign row_hs = bus.row_valid && bus.row_ready;

  pool_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ISSUE),
    .enable (state == WAIT),
    .expire (expire)
  );

  // row_ready and busy are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      win_cnt        <= '0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      bus.row_ready  <= 1'b0;
      bus.pool_start <= 1'b0;
      bus.pool_in    <= '0;
      bus.res_data   <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_last   <= 1'b0;
    end else begin
      bus.pool_start <= 1'b0;
      case (state)
        IDLE: begin
          bus.row_ready <= 1'b1;
          if (row_hs) begin
            bus.pool_in[2*ROW_W-1:ROW_W] <= bus.row_data;
            busy  <= 1'b1;
            state <= FILL_B;
          end
        end
        FILL_B: begin
          if (row_hs) begin
            bus.pool_in[ROW_W-1:0] <= bus.row_data;
            bus.pool_start <= 1'b1;
            bus.row_ready  <= 1'b0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle still wins over the timeout.
          if (bus.pool_end) begin
            bus.res_data  <= bus.pool_out;
            bus.res_valid <= 1'b1;
            bus.res_last  <= (win_cnt == LAST_WIN);
            state         <= OUT;
          end else if (expire) begin
            timeout_err   <= 1'b1;
            bus.row_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.res_last  <= 1'b0;
            win_cnt       <= (win_cnt == LAST_WIN) ? '0 : win_cnt + 1'b1;
            bus.row_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pool_window_issuer.md
Name: pool_window_issuer

Overview:
- Upstream driver and result collector for the 8-wide binary max-pooling slide unit.
- Accepts binarised conv-output rows on a valid/ready stream and pairs consecutive rows into one 144-bit window.
- Issues the window to the pooling unit with a one-cycle start pulse, waits for its end pulse, then forwards the 16-bit pooled result downstream on a valid/ready stream with a frame-last marker.

Parameters:
- ROW_W, 72: bits per input row; window width is 2*ROW_W.
- RES_W, 16: pooled result width.
- WIN_PER_FRAME, 8: windows per frame; the last result of a frame carries res_last. Legal range 1..255.
- TIMEOUT, 64: cycles to wait for pool_end before flagging an error. Legal range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- row_data  in  ROW_W  binarised row
- row_valid  in  1  row_data valid
- row_ready  out  1  block accepts a row this cycle
- pool_start  out  1  one-cycle start pulse to the pooling unit
- pool_in  out  2*ROW_W  window; first row in [143:72], second row in [71:0]
- pool_out  in  RES_W  pooled result
- pool_end  in  1  one-cycle result-valid pulse from the pooling unit
- res_data  out  RES_W  registered result
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts the result
- res_last  out  1  high with res_valid on the last window of a frame
- busy  out  1  high whenever the state is not IDLE
- timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset values: every output is 0, including pool_in and res_data. State is IDLE, window counter is 0, timeout counter is 0.
- Row handshake: a row is accepted on a cycle with row_valid & row_ready.
- Result handshake: a result is accepted on a cycle with res_valid & res_ready.

FSM states and transitions:
- IDLE: row_ready=1. On a row handshake, latch the row into pool_in[143:72] and go to FILL_B.
- FILL_B: row_ready=1. On a row handshake, latch the row into pool_in[71:0] and go to ISSUE.
- ISSUE: row_ready=0. Drive pool_start=1 for exactly this one cycle, clear the timeout counter, go to WAIT.
- WAIT: row_ready=0, pool_start=0.
  - On pool_end: capture pool_out into res_data, assert res_valid, set res_last=(win_cnt==WIN_PER_FRAME-1), go to OUT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 with no pool_end: set timeout_err, discard the window, go to IDLE. win_cnt is not advanced.
- OUT: hold res_data, res_valid and res_last stable until handshake.
  - On handshake: drop res_valid and res_last.
  - Advance win_cnt, wrapping to 0 after WIN_PER_FRAME-1.
  - Go to IDLE.

Timing and rules:
- pool_in is stable from the ISSUE cycle until the state leaves WAIT. The pooling unit samples pool_in on start; pool_in must not change while it is sampling.
- Never more than one window outstanding. No row is accepted from ISSUE through OUT.
- pool_end outside WAIT is ignored (spurious). It must not alter res_data.
- Best-case latency:
  - second row handshake to pool_start: 1 cycle;
  - pool_end to res_valid: 1 cycle;
  - res handshake to row_ready: 1 cycle.
- pool_end in the same cycle the timeout expires: pool_end wins, the result is captured and no error is set.
- Mid-operation reset: abandon everything and return to the reset values on the next edge. A pool_end arriving afterwards is ignored.
- The result path is registered only; no combinational path from res_ready to res_valid. row_ready is a decode of state only.

Decomposition:
- Shared package (cnn_pool_pkg): FSM state encoding (IDLE, FILL_B, ISSUE, WAIT, OUT), ROW_W/RES_W defaults, window-layout constants (WIN_HI_MSB=143, WIN_LO_MSB=71).
- One natural sub-module: pool_timeout_cnt. It provides the clearable timeout counter and produces the expire pulse.

Test Plan:
- Basic window flow:
  - Stimulus: rows 72'hFFFF_0000_AAAA_5555_00 then 72'h01..., with pool_end 3 cycles after pool_start and pool_out=16'hA5C3.
  - Required: pool_in={row0,row1} exactly while pool_start is high; res_data=16'hA5C3 with res_valid one cycle after pool_end; res_last=0.
- Frame boundary:
  - Stimulus: 8 windows, res_ready tied high.
  - Required: res_last=1 only on the 8th result; the 9th window's result has res_last=0 (counter wrapped).
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles while new rows are offered.
  - Required: res_data and res_valid stable throughout; row_ready=0 throughout; pool_start pulses no more than once per window.
- Timeout:
  - Stimulus: no pool_end, TIMEOUT=64.
  - Required: timeout_err set 64 cycles after pool_start; state returns to IDLE; win_cnt unchanged; the next window proceeds normally.
  - Corner: pool_end arriving on the expiry cycle captures the result and leaves timeout_err=0.
- Spurious and reset:
  - Stimulus: pool_end while IDLE.
  - Required: no res_valid and res_data unchanged.
  - Stimulus: reset asserted during WAIT.
  - Required: all outputs 0 next cycle; a following pool_end is ignored.
